// File: rtl/snake_move_ctrl.sv
// ---------------------------------------------------------------------------
// snake_move_ctrl
//
// Upstream control stage for the snake-head X/Y position counters.
// Divides the system clock down to a game-move tick, turns button presses
// into a committed heading (a 180 degree reversal is never accepted), and on
// every tick issues one step or one wrap-load command to the counter of the
// axis the snake is moving along. The counters' current values come back in
// on x_pos / y_pos and decide between stepping and wrapping.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset
//   btn_up     button levels, already synchronised to clk
//   btn_down
//   btn_left
//   btn_right
//   pause      1 = freeze the divider and suppress all move commands
//   x_pos      current X counter value
//   y_pos      current Y counter value
//   tick       one-cycle move strobe
//   dir        committed heading: 0 RIGHT, 1 LEFT, 2 UP, 3 DOWN
//   step_x     one-cycle X step enable, direction given by x_down
//   x_down     X step direction (1 = decrement), held between commands
//   x_sel      one-cycle X load strobe, value on x_in
//   x_in       X load value, held between commands
//   step_y     one-cycle Y step enable, direction given by y_down
//   y_down     Y step direction (1 = decrement, i.e. UP), held
//   y_sel      one-cycle Y load strobe, value on y_in
//   y_in       Y load value, held between commands
// ---------------------------------------------------------------------------
module snake_move_ctrl #(
    parameter int WIDTH    = 8,
    parameter int X_MAX    = 31,
    parameter int Y_MAX    = 23,
    parameter int TICK_DIV = 1000000,
    parameter int TICK_W   = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             pause,
    input  logic [WIDTH-1:0] x_pos,
    input  logic [WIDTH-1:0] y_pos,
    output logic             tick,
    output logic [1:0]       dir,
    output logic             step_x,
    output logic             x_down,
    output logic             x_sel,
    output logic [WIDTH-1:0] x_in,
    output logic             step_y,
    output logic             y_down,
    output logic             y_sel,
    output logic [WIDTH-1:0] y_in
);

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } heading_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0]  X_MAX_V   = WIDTH'(X_MAX);
    localparam logic [WIDTH-1:0]  Y_MAX_V   = WIDTH'(Y_MAX);

    // Headings are encoded so that opposite directions share bit 1 and
    // differ only in bit 0 (RIGHT/LEFT = 0x, UP/DOWN = 1x).
    function automatic logic is_reverse(input heading_t a, input heading_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    // Feedback beyond the legal range counts as sitting on the far edge,
    // so a corrupted counter still wraps back to 0 instead of running away.
    function automatic logic at_high_edge(input logic [WIDTH-1:0] pos,
                                          input logic [WIDTH-1:0] lim);
        return pos >= lim;
    endfunction

    function automatic logic at_low_edge(input logic [WIDTH-1:0] pos);
        return pos == '0;
    endfunction

    logic [TICK_W-1:0] div_cnt;
    logic [3:0]        btn_prev;      // {up, down, left, right}
    logic [3:0]        btn_now;
    logic [3:0]        btn_rise;
    heading_t          dir_q;
    heading_t          pending;
    heading_t          press_dir;
    heading_t          ref_dir;
    logic              press_vld;
    logic              press_ok;
    logic              commit;

    assign btn_now = {btn_up, btn_down, btn_left, btn_right};
    assign dir     = dir_q;

    // A tick that lands while paused is swallowed: no commit, no strobe.
    assign commit  = tick && !pause;

    // Rising-edge press decode with fixed priority up > down > left > right.
    always_comb begin
        btn_rise  = btn_now & ~btn_prev;
        press_vld = |btn_rise;
        press_dir = RIGHT;
        if (btn_rise[3]) begin
            press_dir = UP;
        end else if (btn_rise[2]) begin
            press_dir = DOWN;
        end else if (btn_rise[1]) begin
            press_dir = LEFT;
        end else if (btn_rise[0]) begin
            press_dir = RIGHT;
        end
    end

    // In the commit cycle the heading about to become current is the one a
    // new press must not reverse; otherwise it is the committed heading.
    always_comb begin
        ref_dir  = commit ? pending : dir_q;
        press_ok = press_vld && !is_reverse(press_dir, ref_dir);
    end

    // Stage boundary: divider, heading registers and move command outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt  <= '0;
            tick     <= 1'b0;
            btn_prev <= '0;
            dir_q    <= RIGHT;
            pending  <= RIGHT;
            step_x   <= 1'b0;
            x_down   <= 1'b0;
            x_sel    <= 1'b0;
            x_in     <= '0;
            step_y   <= 1'b0;
            y_down   <= 1'b0;
            y_sel    <= 1'b0;
            y_in     <= '0;
        end else begin
            btn_prev <= btn_now;

            // Strobes default low; each is raised for a single cycle below.
            tick   <= 1'b0;
            step_x <= 1'b0;
            x_sel  <= 1'b0;
            step_y <= 1'b0;
            y_sel  <= 1'b0;

            if (!pause) begin
                if (div_cnt == TICK_LAST) begin
                    div_cnt <= '0;
                    tick    <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + TICK_W'(1);
                end
            end

            if (commit) begin
                dir_q <= pending;
                unique case (pending)
                    RIGHT: begin
                        if (at_high_edge(x_pos, X_MAX_V)) begin
                            x_sel <= 1'b1;
                            x_in  <= '0;
                        end else begin
                            step_x <= 1'b1;
                            x_down <= 1'b0;
                        end
                    end
                    LEFT: begin
                        if (at_low_edge(x_pos)) begin
                            x_sel <= 1'b1;
                            x_in  <= X_MAX_V;
                        end else begin
                            step_x <= 1'b1;
                            x_down <= 1'b1;
                        end
                    end
                    UP: begin
                        if (at_low_edge(y_pos)) begin
                            y_sel <= 1'b1;
                            y_in  <= Y_MAX_V;
                        end else begin
                            step_y <= 1'b1;
                            y_down <= 1'b1;
                        end
                    end
                    DOWN: begin
                        if (at_high_edge(y_pos, Y_MAX_V)) begin
                            y_sel <= 1'b1;
                            y_in  <= '0;
                        end else begin
                            step_y <= 1'b1;
                            y_down <= 1'b0;
                        end
                    end
                endcase
            end

            // Last accepted press before the tick wins; a press in the commit
            // cycle itself is queued for the following tick.
            if (press_ok) begin
                pending <= press_dir;
            end
        end
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_move_ctrl
//
// Directed bench for snake_move_ctrl with TICK_DIV = 4. A cycle-by-cycle
// vector table drives buttons and counter feedback and lists the expected
// output bundle after each clock edge; hand-written sequences then cover
// pause freezing, press capture during pause, and reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_snake_move_ctrl;

    localparam int WIDTH    = 8;
    localparam int X_MAX    = 31;
    localparam int Y_MAX    = 23;
    localparam int TICK_DIV = 4;
    localparam int TICK_W   = 4;

    logic             clk;
    logic             reset;
    logic             btn_up, btn_down, btn_left, btn_right;
    logic             pause;
    logic [WIDTH-1:0] x_pos, y_pos;
    logic             tick;
    logic [1:0]       dir;
    logic             step_x, x_down, x_sel;
    logic [WIDTH-1:0] x_in;
    logic             step_y, y_down, y_sel;
    logic [WIDTH-1:0] y_in;

    snake_move_ctrl #(
        .WIDTH    (WIDTH),
        .X_MAX    (X_MAX),
        .Y_MAX    (Y_MAX),
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .pause     (pause),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .tick      (tick),
        .dir       (dir),
        .step_x    (step_x),
        .x_down    (x_down),
        .x_sel     (x_sel),
        .x_in      (x_in),
        .step_y    (step_y),
        .y_down    (y_down),
        .y_sel     (y_sel),
        .y_in      (y_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {tick, dir, step_x, x_down, x_sel, x_in, step_y, y_down, y_sel, y_in}
    typedef logic [24:0] bundle_t;

    typedef struct {
        logic [3:0]       btn;   // {up, down, left, right}
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        bundle_t          exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic bundle_t mk(input bit tk, input int d, input bit sx, input bit xd,
                                   input bit xs, input int xi, input bit sy, input bit yd,
                                   input bit ys, input int yi);
        return {tk, 2'(d), sx, xd, xs, 8'(xi), sy, yd, ys, 8'(yi)};
    endfunction

    function automatic vec_t v(input logic [3:0] b, input int x, input int y, input bundle_t e);
        vec_t r;
        r.btn = b;
        r.x   = 8'(x);
        r.y   = 8'(y);
        r.exp = e;
        return r;
    endfunction

    function automatic bundle_t observed();
        return {tick, dir, step_x, x_down, x_sel, x_in, step_y, y_down, y_sel, y_in};
    endfunction

    task automatic check(input string name, input bundle_t act, input bundle_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    initial begin
        bundle_t z;
        z = '0;

        // Buttons {u,d,l,r}, x_pos, y_pos, expected after the edge.
        // Test 1: free-running RIGHT, tick on every 4th edge, step one edge later.
        repeat (3) vecs.push_back(v(4'b0000, 5, 7, z));
        vecs.push_back(v(4'b0000, 5, 7, mk(1,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(v(4'b0000, 5, 7, mk(0,0,1,0,0,0,0,0,0,0)));
        repeat (2) vecs.push_back(v(4'b0000, 5, 7, z));
        vecs.push_back(v(4'b0000, 5, 7, mk(1,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(v(4'b0000, 5, 7, mk(0,0,1,0,0,0,0,0,0,0)));
        // Test 2: LEFT while RIGHT is rejected.
        vecs.push_back(v(4'b0010, 5, 7, z));
        vecs.push_back(v(4'b0000, 5, 7, z));
        vecs.push_back(v(4'b0000, 5, 7, mk(1,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(v(4'b0000, 5, 7, mk(0,0,1,0,0,0,0,0,0,0)));
        // Test 3: UP accepted, then LEFT rejected against committed RIGHT.
        vecs.push_back(v(4'b1000, 5, 7, z));
        vecs.push_back(v(4'b0010, 5, 7, z));
        vecs.push_back(v(4'b0000, 5, 7, mk(1,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(v(4'b0000, 5, 7, mk(0,2,0,0,0,0,1,1,0,0)));
        // Test 4: UP at y=0 wraps to Y_MAX; RIGHT at x=31 wraps to 0.
        repeat (2) vecs.push_back(v(4'b0000, 5, 0, mk(0,2,0,0,0,0,0,1,0,0)));
        vecs.push_back(v(4'b0000, 5, 0, mk(1,2,0,0,0,0,0,1,0,0)));
        vecs.push_back(v(4'b0000, 5, 0, mk(0,2,0,0,0,0,0,1,1,23)));
        vecs.push_back(v(4'b0001, 31, 0, mk(0,2,0,0,0,0,0,1,0,23)));
        vecs.push_back(v(4'b0000, 31, 0, mk(0,2,0,0,0,0,0,1,0,23)));
        vecs.push_back(v(4'b0000, 31, 0, mk(1,2,0,0,0,0,0,1,0,23)));
        vecs.push_back(v(4'b0000, 31, 0, mk(0,0,0,0,1,0,0,1,0,23)));
        // Turn UP (step), then LEFT at x=0 wraps to X_MAX.
        vecs.push_back(v(4'b1000, 31, 10, mk(0,0,0,0,0,0,0,1,0,23)));
        vecs.push_back(v(4'b0000, 31, 10, mk(0,0,0,0,0,0,0,1,0,23)));
        vecs.push_back(v(4'b0000, 31, 10, mk(1,0,0,0,0,0,0,1,0,23)));
        vecs.push_back(v(4'b0000, 31, 10, mk(0,2,0,0,0,0,1,1,0,23)));
        vecs.push_back(v(4'b0010, 0, 10, mk(0,2,0,0,0,0,0,1,0,23)));
        vecs.push_back(v(4'b0000, 0, 10, mk(0,2,0,0,0,0,0,1,0,23)));
        vecs.push_back(v(4'b0000, 0, 10, mk(1,2,0,0,0,0,0,1,0,23)));
        vecs.push_back(v(4'b0000, 0, 10, mk(0,1,0,0,1,31,0,1,0,23)));
        // Test 5: UP and RIGHT rise together while LEFT: UP wins.
        vecs.push_back(v(4'b1001, 0, 10, mk(0,1,0,0,0,31,0,1,0,23)));
        vecs.push_back(v(4'b0000, 0, 10, mk(0,1,0,0,0,31,0,1,0,23)));
        vecs.push_back(v(4'b0000, 0, 10, mk(1,1,0,0,0,31,0,1,0,23)));
        vecs.push_back(v(4'b0000, 0, 10, mk(0,2,0,0,0,31,1,1,0,23)));
        // LEFT step from x=9 decrements.
        vecs.push_back(v(4'b0010, 9, 10, mk(0,2,0,0,0,31,0,1,0,23)));
        vecs.push_back(v(4'b0000, 9, 10, mk(0,2,0,0,0,31,0,1,0,23)));
        vecs.push_back(v(4'b0000, 9, 10, mk(1,2,0,0,0,31,0,1,0,23)));
        vecs.push_back(v(4'b0000, 9, 10, mk(0,1,1,1,0,31,0,1,0,23)));
        // DOWN with y=30 beyond Y_MAX loads 0, then DOWN steps up from y=5.
        vecs.push_back(v(4'b0100, 9, 30, mk(0,1,0,1,0,31,0,1,0,23)));
        vecs.push_back(v(4'b0000, 9, 30, mk(0,1,0,1,0,31,0,1,0,23)));
        vecs.push_back(v(4'b0000, 9, 30, mk(1,1,0,1,0,31,0,1,0,23)));
        vecs.push_back(v(4'b0000, 9, 30, mk(0,3,0,1,0,31,0,1,1,0)));
        repeat (2) vecs.push_back(v(4'b0000, 9, 5, mk(0,3,0,1,0,31,0,1,0,0)));
        vecs.push_back(v(4'b0000, 9, 5, mk(1,3,0,1,0,31,0,1,0,0)));
        vecs.push_back(v(4'b0000, 9, 5, mk(0,3,0,1,0,31,1,0,0,0)));
        // RIGHT pending; LEFT pressed in the commit cycle is the reverse of
        // the newly committed RIGHT and must be rejected.
        vecs.push_back(v(4'b0001, 5, 5, mk(0,3,0,1,0,31,0,0,0,0)));
        vecs.push_back(v(4'b0000, 5, 5, mk(0,3,0,1,0,31,0,0,0,0)));
        vecs.push_back(v(4'b0000, 5, 5, mk(1,3,0,1,0,31,0,0,0,0)));
        vecs.push_back(v(4'b0010, 5, 5, mk(0,0,1,0,0,31,0,0,0,0)));
        repeat (2) vecs.push_back(v(4'b0000, 5, 5, mk(0,0,0,0,0,31,0,0,0,0)));
        vecs.push_back(v(4'b0000, 5, 5, mk(1,0,0,0,0,31,0,0,0,0)));
        vecs.push_back(v(4'b0000, 5, 5, mk(0,0,1,0,0,31,0,0,0,0)));

        // Reset state.
        reset = 1'b0;
        pause = 1'b0;
        set_btn(4'b0000);
        x_pos = 8'd5;
        y_pos = 8'd7;
        edge_step();
        edge_step();
        check("reset_state", observed(), '0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            set_btn(vecs[i].btn);
            x_pos = vecs[i].x;
            y_pos = vecs[i].y;
            edge_step();
            check($sformatf("vec%0d", i + 1), observed(), vecs[i].exp);
        end

        // Pause for 12 edges with divider at 1; an UP press is still captured.
        set_btn(4'b0000);
        pause = 1'b1;
        for (int i = 0; i < 12; i++) begin
            btn_up = (i == 0);
            edge_step();
            check($sformatf("pause%0d", i), {tick, step_x, x_sel, step_y, y_sel}, 5'b0);
        end
        btn_up = 1'b0;
        pause  = 1'b0;
        // Divider resumes from 1: tick on the third edge.
        edge_step();
        check_bit("resume1_tick", tick, 1'b0);
        edge_step();
        check_bit("resume2_tick", tick, 1'b0);
        edge_step();
        check("resume3", observed(), mk(1,0,0,0,0,31,0,0,0,0));
        edge_step();
        check("resume_commit_up", observed(), mk(0,2,0,0,0,31,1,1,0,0));
        edge_step();
        edge_step();
        edge_step();
        check("pre_reset_tick", observed(), mk(1,2,0,0,0,31,0,1,0,0));

        // Reset one cycle after a tick drops the pending command.
        reset = 1'b0;
        set_btn(4'b0100);
        edge_step();
        check("mid_reset", observed(), '0);
        set_btn(4'b0000);
        edge_step();
        check("mid_reset_hold", observed(), '0);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            edge_step();
            check($sformatf("post_reset%0d", i), observed(), '0);
        end
        edge_step();
        check("post_reset_tick", observed(), mk(1,0,0,0,0,0,0,0,0,0));
        edge_step();
        check("post_reset_step", observed(), mk(0,0,1,0,0,0,0,0,0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
